// File: rtl/nacc_sequencer_if.sv
// NACC sequencer bus: instruction/operand inputs from ID/EX, control outputs.
// master = EX/pipeline side, slave = sequencer.
interface nacc_sequencer_if;
  logic        nacc_valid;
  logic [1:0]  vl;
  logic [15:0] spike_mask;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [3:0]  lane_idx;
  logic        acc_en;
  logic        acc_clr;
  logic        done;
  logic        empty;

  modport master (
    output nacc_valid, vl, spike_mask, flush,
    input  stall, busy, lane_idx,
    input  acc_en, acc_clr, done, empty
  );

  modport slave (
    input  nacc_valid, vl, spike_mask, flush,
    output stall, busy, lane_idx,
    output acc_en, acc_clr, done, empty
  );
endinterface

// File: rtl/nacc_sequencer.sv
// NACC multi-cycle sequencer: steps 32-bit WVR lanes into the accumulator.
// Ports: clk, reset (sync, active-high), bus (nacc_sequencer_if.slave).
// Option: NACC_SKIP_EN skips lanes whose spike_mask bit is 0.
module nacc_sequencer (
  input logic              clk,
  input logic              reset,
  nacc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  lane_q, lane_d;
  logic [1:0]  vl_q, vl_d;
  logic        first_q, first_d;
  logic        live;
  logic        start;

`ifdef NACC_SKIP_EN
  logic [15:0] mask_q, mask_d;
  logic        empty_q, empty_d;
  logic [4:0]  nxt;

  // {found, idx}: lowest set mask bit at or above lo within the active lanes
  function automatic logic [4:0] find_next(
    input logic [15:0] m,
    input logic [1:0]  v,
    input logic [4:0]  lo
  );
    logic [4:0] r;
    int         lim;
    r   = '0;
    lim = 4 * (int'(v) + 1);
    for (int i = 15; i >= 0; i--) begin
      if (i >= int'(lo) && i < lim && m[i]) begin
        r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      vl_q    <= '0;
      first_q <= 1'b0;
`ifdef NACC_SKIP_EN
      mask_q  <= '0;
      empty_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      vl_q    <= vl_d;
      first_q <= first_d;
`ifdef NACC_SKIP_EN
      mask_q  <= mask_d;
      empty_q <= empty_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    vl_d         = vl_q;
    first_d      = first_q;
`ifdef NACC_SKIP_EN
    mask_d       = mask_q;
    empty_d      = empty_q;
    nxt          = '0;
`endif
    bus.stall    = 1'b0;
    bus.busy     = 1'b0;
    bus.lane_idx = '0;
    bus.acc_en   = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.done     = 1'b0;
    bus.empty    = 1'b0;

    // Reset and flush both squash every control strobe this cycle.
    live  = ~bus.flush & ~reset;
    start = bus.nacc_valid & ~bus.flush;

    bus.busy = (state_q != S_IDLE) & ~reset;

    unique case (state_q)
      S_IDLE: begin
        bus.stall = bus.nacc_valid & live;
        if (start) begin
          vl_d    = bus.vl;
          first_d = 1'b1;
`ifdef NACC_SKIP_EN
          mask_d  = bus.spike_mask;
          nxt     = find_next(bus.spike_mask, bus.vl, 5'd0);
          lane_d  = nxt[3:0];
          empty_d = ~nxt[4];
          state_d = nxt[4] ? S_RUN : S_DONE;
`else
          lane_d  = '0;
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        bus.stall    = live;
        bus.acc_en   = live;
        bus.acc_clr  = first_q & live;
        bus.lane_idx = reset ? 4'd0 : lane_q;
        first_d      = 1'b0;
`ifdef NACC_SKIP_EN
        nxt = find_next(mask_q, vl_q, {1'b0, lane_q} + 5'd1);
        if (nxt[4]) lane_d = nxt[3:0];
        else        state_d = S_DONE;
`else
        // Last active lane is 4*(vl+1)-1 == {vl, 2'b11}.
        if (lane_q == {vl_q, 2'b11}) state_d = S_DONE;
        else                         lane_d  = lane_q + 4'd1;
`endif
      end
      S_DONE: begin
        bus.done = live;
`ifdef NACC_SKIP_EN
        bus.empty = empty_q & live;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) state_d = S_IDLE;
  end

endmodule
